// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// States are plain 2-bit constants so legacy code can compare them directly.
package mem_arbiter_pkg;

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t ARB_IDLE   = 2'd0;
   localparam arb_state_t ARB_BUSY_I = 2'd1;
   localparam arb_state_t ARB_BUSY_D = 2'd2;
   localparam arb_state_t ARB_DONE   = 2'd3;

   typedef enum logic {
      ARB_PORT_I = 1'b0,
      ARB_PORT_D = 1'b1
   } arb_port_t;

   localparam logic [1:0] MEM_SIZE_B = 2'b00;
   localparam logic [1:0] MEM_SIZE_H = 2'b01;
   localparam logic [1:0] MEM_SIZE_W = 2'b10;

   // Round-robin: on a tie the port that did not win last time is chosen.
   function automatic logic pick_fetch(input logic fetch_req, input logic data_req,
                                       input arb_port_t last);
      return fetch_req && (!data_req || (last == ARB_PORT_D));
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (I) and load/store (D).
// One transaction in flight; completion is a one-cycle ready pulse to the winner.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic [DATA_WIDTH-1:0] i_rdata,
   output logic                  i_ready,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   input  logic [1:0]            d_size,
   input  logic                  d_sign,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_ready,
   output logic                  m_valid,
   output logic                  m_we,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [DATA_WIDTH-1:0] m_wdata,
   output logic [1:0]            m_size,
   output logic                  m_sign,
   input  logic [DATA_WIDTH-1:0] m_rdata,
   input  logic                  m_ready
);

   arb_state_t state;
   arb_port_t  last_grant;
   logic       grant_i;
   logic       grant_d;

   assign grant_i = pick_fetch(i_req, d_req, last_grant);
   assign grant_d = d_req && !grant_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARB_IDLE;
         last_grant <= ARB_PORT_D;
         m_valid    <= 1'b0;
         m_we       <= 1'b0;
         m_addr     <= '0;
         m_wdata    <= '0;
         m_size     <= '0;
         m_sign     <= 1'b0;
         i_ready    <= 1'b0;
         d_ready    <= 1'b0;
         i_rdata    <= '0;
         d_rdata    <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (grant_i) begin
                  m_valid    <= 1'b1;
                  m_we       <= 1'b0;
                  m_addr     <= i_addr;
                  m_wdata    <= '0;
                  m_size     <= MEM_SIZE_W;
                  m_sign     <= 1'b1;
                  last_grant <= ARB_PORT_I;
                  state      <= ARB_BUSY_I;
               end else if (grant_d) begin
                  m_valid    <= 1'b1;
                  m_we       <= d_we;
                  m_addr     <= d_addr;
                  m_wdata    <= d_wdata;
                  m_size     <= d_size;
                  m_sign     <= d_sign;
                  last_grant <= ARB_PORT_D;
                  state      <= ARB_BUSY_D;
               end
            end
            ARB_BUSY_I: begin
               if (m_ready) begin
                  i_rdata <= m_rdata;
                  i_ready <= 1'b1;
                  m_valid <= 1'b0;
                  state   <= ARB_DONE;
               end
            end
            ARB_BUSY_D: begin
               if (m_ready) begin
                  // Stores leave the last load result visible.
                  if (!m_we) begin
                     d_rdata <= m_rdata;
                  end
                  d_ready <= 1'b1;
                  m_valid <= 1'b0;
                  state   <= ARB_DONE;
               end
            end
            ARB_DONE: begin
               i_ready <= 1'b0;
               d_ready <= 1'b0;
               state   <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requesters and a memory model drive the DUT,
// a cycle reference checks every output, and per-port queues hold expected results.
module tb_mem_arbiter;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        sign;
      logic [31:0] rdata;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic [31:0] i_rdata;
   logic        i_ready;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [1:0]  d_size = '0;
   logic        d_sign = 1'b0;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        m_valid;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [1:0]  m_size;
   logic        m_sign;
   logic [31:0] m_rdata = '0;
   logic        m_ready = 1'b0;

   mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_size(d_size), .d_sign(d_sign), .d_rdata(d_rdata), .d_ready(d_ready),
      .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_size(m_size), .m_sign(m_sign), .m_rdata(m_rdata), .m_ready(m_ready)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   txn_t        i_todo[$];
   txn_t        d_todo[$];
   txn_t        i_exp[$];
   txn_t        d_exp[$];
   logic [31:0] mem_map [logic [31:0]];
   bit          gnt_log[$];
   bit          i_hold = 1'b0;
   bit          idle_ready = 1'b0;
   int          mem_wait = 0;
   int          wcnt = 0;
   int          ir_cnt = 0;

   task automatic push_fetch(input logic [31:0] a, input logic [31:0] rd);
      txn_t t;
      t = '{addr: a, we: 1'b0, wdata: 32'h0, size: 2'b10, sign: 1'b1, rdata: rd};
      mem_map[a] = rd;
      i_todo.push_back(t);
      i_exp.push_back(t);
   endtask

   task automatic push_data(input logic [31:0] a, input logic we, input logic [31:0] wd,
                            input logic [1:0] sz, input logic sg, input logic [31:0] rd);
      txn_t t;
      t = '{addr: a, we: we, wdata: wd, size: sz, sign: sg, rdata: rd};
      mem_map[a] = rd;
      d_todo.push_back(t);
      d_exp.push_back(t);
   endtask

   // Fetch requester: drops req in the ready cycle unless holding
   always @(negedge clk) begin
      txn_t t;
      if (i_req && i_ready) begin
         if (i_hold && i_todo.size() > 0) begin
            t = i_todo.pop_front();
            i_addr = t.addr;
         end else begin
            i_req = 1'b0;
         end
      end else if (!i_req && i_todo.size() > 0) begin
         t = i_todo.pop_front();
         i_addr = t.addr;
         i_req = 1'b1;
      end
   end

   always @(negedge clk) begin
      txn_t t;
      if (d_req && d_ready) begin
         d_req = 1'b0;
      end else if (!d_req && d_todo.size() > 0) begin
         t = d_todo.pop_front();
         d_addr  = t.addr;
         d_we    = t.we;
         d_wdata = t.wdata;
         d_size  = t.size;
         d_sign  = t.sign;
         d_req   = 1'b1;
      end
   end

   // Memory model with configurable wait states; junk data while not ready
   always @(negedge clk) begin
      if (!m_valid) begin
         wcnt    = 0;
         m_ready = idle_ready;
         m_rdata = 32'hBAD0_0BAD;
      end else begin
         if (wcnt >= mem_wait) begin
            m_ready = 1'b1;
            m_rdata = mem_map.exists(m_addr) ? mem_map[m_addr] : 32'h1234_5678;
         end else begin
            m_ready = 1'b0;
            m_rdata = 32'hBAD0_0BAD;
         end
         wcnt++;
      end
   end

   // Cycle reference of the arbiter, compared against every output after each edge
   int          mst = 0;
   bit          mport = 1'b0;
   bit          mlg = 1'b1;
   logic        e_valid = 0, e_we = 0, e_sign = 0, e_iready = 0, e_dready = 0;
   logic [31:0] e_addr = 0, e_wdata = 0, e_irdata = 0, e_drdata = 0;
   logic [1:0]  e_size = 0;
   logic        s_rst, s_ireq, s_dreq, s_mrdy, s_dwe, s_dsign;
   logic [31:0] s_iaddr, s_daddr, s_dwdata;
   logic [1:0]  s_dsize;

   always @(posedge clk) begin
      txn_t t;
      s_rst = rst_n;  s_ireq = i_req;  s_dreq = d_req;  s_mrdy = m_ready;
      s_iaddr = i_addr;  s_daddr = d_addr;  s_dwe = d_we;  s_dwdata = d_wdata;
      s_dsize = d_size;  s_dsign = d_sign;
      #1;
      if (!s_rst) begin
         mst = 0; mlg = 1'b1;
         e_valid = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_size = 0; e_sign = 0;
         e_iready = 0; e_dready = 0; e_irdata = 0; e_drdata = 0;
      end else begin
         case (mst)
            0: begin
               if (s_ireq && (!s_dreq || mlg)) begin
                  e_valid = 1; e_we = 0; e_addr = s_iaddr; e_wdata = 0; e_size = 2'b10; e_sign = 1;
                  mport = 0; mlg = 0; mst = 1; gnt_log.push_back(1'b0);
               end else if (s_dreq) begin
                  e_valid = 1; e_we = s_dwe; e_addr = s_daddr; e_wdata = s_dwdata;
                  e_size = s_dsize; e_sign = s_dsign;
                  mport = 1; mlg = 1; mst = 1; gnt_log.push_back(1'b1);
               end
            end
            1: begin
               if (s_mrdy) begin
                  e_valid = 0; mst = 2;
                  if (!mport) begin
                     e_iready = 1;
                     if (i_exp.size() == 0) chk("sb_i_empty", 64'd1, 64'd0);
                     else begin t = i_exp.pop_front(); e_irdata = t.rdata; end
                  end else begin
                     e_dready = 1;
                     if (d_exp.size() == 0) chk("sb_d_empty", 64'd1, 64'd0);
                     else begin t = d_exp.pop_front(); if (!t.we) e_drdata = t.rdata; end
                  end
               end
            end
            default: begin
               e_iready = 0; e_dready = 0; mst = 0;
            end
         endcase
      end
      if (i_ready) ir_cnt++;
      chk("m_valid", m_valid, e_valid);
      chk("m_we", m_we, e_we);
      chk("m_addr", m_addr, e_addr);
      chk("m_wdata", m_wdata, e_wdata);
      chk("m_size", m_size, e_size);
      chk("m_sign", m_sign, e_sign);
      chk("i_ready", i_ready, e_iready);
      chk("d_ready", d_ready, e_dready);
      chk("i_rdata", i_rdata, e_irdata);
      chk("d_rdata", d_rdata, e_drdata);
   end

   task automatic wait_idle(input string tag);
      bit done = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (i_todo.size() == 0 && d_todo.size() == 0 && i_exp.size() == 0 &&
             d_exp.size() == 0 && !i_req && !d_req && !m_valid && !i_ready && !d_ready) begin
            done = 1'b1;
            break;
         end
      end
      chk(tag, done, 1'b1);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int ir0;
      bit seen;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_m_addr", m_addr, 32'h0);
      chk("rst_i_ready", i_ready, 1'b0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Single fetch, zero-wait memory
      @(posedge clk); #2;
      push_fetch(32'h100, 32'h0050_0093);
      wait_idle("fetch_drain");
      chk("fetch_rdata", i_rdata, 32'h0050_0093);

      // Byte store with three wait states; d_rdata must stay put
      mem_wait = 3;
      @(posedge clk); #2;
      push_data(32'h2004, 1'b1, 32'hDEAD_BEEF, 2'b00, 1'b0, 32'h5555_AAAA);
      wait_idle("store_drain");
      chk("store_d_rdata", d_rdata, 32'h0);

      // Ties after reset alternate I, D, I, D, I, D
      mem_wait = 0;
      apply_reset();
      gnt_log.delete();
      @(posedge clk); #2;
      for (int k = 0; k < 3; k++) begin
         push_fetch(32'h400 + 32'(k * 4), 32'hA000_0000 + 32'(k));
         push_data(32'h500 + 32'(k * 4), 1'b0, 32'h0, 2'b10, 1'b0, 32'hB000_0000 + 32'(k));
      end
      wait_idle("rr_drain");
      chk("rr_count", gnt_log.size(), 6);
      for (int k = 0; k < 6 && k < gnt_log.size(); k++)
         chk($sformatf("rr_grant%0d", k), gnt_log[k], k % 2);

      // Sign-extending byte load
      mem_wait = 1;
      @(posedge clk); #2;
      push_data(32'h3001, 1'b0, 32'h0, 2'b00, 1'b1, 32'hFFFF_FF80);
      wait_idle("lb_drain");
      chk("lb_d_rdata", d_rdata, 32'hFFFF_FF80);

      // Reset in the second BUSY_D cycle, then the held request is reissued
      mem_wait = 3;
      @(posedge clk); #2;
      push_data(32'h600, 1'b0, 32'h0, 2'b10, 1'b0, 32'hC0DE_0600);
      seen = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (m_valid) begin seen = 1'b1; break; end
      end
      chk("rst_mid_seen_valid", seen, 1'b1);
      @(negedge clk);
      chk("rst_mid_pre_valid", m_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_m_valid", m_valid, 1'b0);
      chk("rst_mid_m_addr", m_addr, 32'h0);
      chk("rst_mid_m_size", m_size, 2'b00);
      chk("rst_mid_d_ready", d_ready, 1'b0);
      chk("rst_mid_d_rdata", d_rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("reissue_valid", m_valid, 1'b1);
      chk("reissue_addr", m_addr, 32'h600);
      wait_idle("reissue_drain");
      chk("reissue_d_rdata", d_rdata, 32'hC0DE_0600);

      // Held fetch request is a new request; m_ready in IDLE is ignored
      mem_wait = 0;
      idle_ready = 1'b1;
      repeat (4) @(negedge clk);
      ir0 = ir_cnt;
      i_hold = 1'b1;
      @(posedge clk); #2;
      push_fetch(32'h200, 32'h1111_0200);
      push_fetch(32'h204, 32'h2222_0204);
      wait_idle("hold_drain");
      chk("hold_ready_pulses", ir_cnt - ir0, 2);
      chk("hold_i_rdata", i_rdata, 32'h2222_0204);
      i_hold = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle_mready_pulses", ir_cnt - ir0, 2);
      idle_ready = 1'b0;

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
